featuremap_accumulator: RTL
===========================

# featuremap_accumulator

Parametrised per-output-channel accumulator that sits directly behind a bank of per-input-channel 3x3 convolution units in a YOLOv3-Tiny layer. It sums CHANNELS partial results in a pipelined adder tree, adds the bias, applies the selected activation, saturates the result, and tracks pixel position within the IMG_SIZE x IMG_SIZE output feature map. It replaces hand-written per-layer feature-map wrappers with one generic block.

## Interface
- CHANNELS, 32: input channel count; power of two, 2..256
- DATA_WIDTH, 16: signed fixed-point sample width
- FRAC_BITS, 8: fractional bits; informational only, since the bias already uses the same scale
- IMG_SIZE, 104: output feature-map side length
- BIAS, 0: signed DATA_WIDTH bias, same fixed-point scale as data
- ACT_MODE, 2: activation select; 0 = linear, 1 = ReLU, 2 = leaky (slope 1/8)

- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- data_in  in  CHANNELS*DATA_WIDTH  packed partials; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  1  all lanes valid this cycle
- data_out  out  DATA_WIDTH  activated, saturated result
- valid_out  out  1  data_out valid
- line_end  out  1  with valid_out: last pixel of a row
- frame_end  out  1  with valid_out: last pixel of the frame

## Operation
- Let S = log2(CHANNELS) and AW = DATA_WIDTH + S + 1.
- Adder tree:
  - Stage 0 registers each lane sign-extended to AW.
  - Stages 1..S each halve the operand count with registered pairwise adds.
  - Full precision is kept throughout; no overflow is possible.
- Bias stage: sum + sign-extended BIAS, registered.
- Activation/saturate stage, registered:
  - ACT_MODE 0: pass x unchanged.
  - ACT_MODE 1: x<0 → 0.
  - ACT_MODE 2: x<0 → x>>>3 (arithmetic shift, floor).
  - Then clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- A valid bit travels alongside every stage. Stages with valid low hold their data registers (no toggling).
- Position counters col and row:
  - Both advance only on valid_out.
  - col wraps IMG_SIZE-1 → 0; row increments on that wrap.
  - row wraps IMG_SIZE-1 → 0 on the frame's last pixel.
  - line_end = valid_out & (col == IMG_SIZE-1).
  - frame_end = line_end & (row == IMG_SIZE-1).
  - line_end and frame_end are combinational from registered counters and valid_out.
- There is no back-pressure. Downstream must accept one result per cycle.
- An illegal CHANNELS value (not a power of two) must stop elaboration with $error.

## Timing
- Latency is S+3 cycles from valid_in to valid_out. Default: 8 cycles.
- Throughput is one result per cycle. Back-to-back valid_in produces back-to-back valid_out in order.
- Bubbles in valid_in propagate unchanged. Counters do not advance in bubbles.
- Reset, asynchronous on Rst low:
  - All valid bits, col and row clear to 0.
  - data_out resets to 0; valid_out, line_end and frame_end are 0.
  - Data registers may be reset or left unreset. data_out must be reset.
- Reset mid-frame: in-flight samples are discarded, and the next accepted sample is pixel (0,0).
- The first valid_out is permitted S+3 cycles after the first valid_in sampled with Rst high.
- Frame wrap: the cycle after frame_end, the next valid result is (0,0) with no dead cycle.

## Structure
- Shared package conv_pkg holds:
  - ACT_LINEAR/ACT_RELU/ACT_LEAKY localparams
  - a clog2 helper
  - a sat_to_width function
  - LEAKY_SHIFT = 3
- Sub-module featuremap_adder_tree, parametrised by CHANNELS and AW, implements stages 0..S and carries the valid pipeline.
- The top level holds the bias stage, activation/saturation and the position counters.

## Test plan
- CHANNELS=4, DATA_WIDTH=16, BIAS=0x0100, ACT_MODE=2:
  - Lanes {0x0100,0x0200,0x0300,0x0400}, one valid pulse → after 5 cycles data_out=0x0B00, valid_out for exactly 1 cycle.
  - Same configuration, all lanes 0xF000 → sum+bias = -0x3F00; leaky gives 0xF820.
- Saturation, ACT_MODE=0, CHANNELS=32, all lanes 0x7FFF → data_out=0x7FFF. All lanes 0x8000 → 0x8000.
- ACT_MODE=1, lanes summing to -5 → data_out=0x0000.
- IMG_SIZE=4, 16 consecutive valids:
  - line_end on outputs 3, 7, 11, 15; frame_end only on output 15.
  - A 17th valid gives col=0, row=0 with no gap.
  - Inserting random valid_in bubbles gives identical flag positions counted in valid outputs.
- Reset mid-pipeline: assert Rst low for 1 cycle while 3 samples are in flight → no valid_out for those samples. The next frame's first output has line_end=0 and the counters are restarted.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution datapath blocks.
package conv_pkg;
  localparam int ACT_LINEAR  = 0;
  localparam int ACT_RELU    = 1;
  localparam int ACT_LEAKY   = 2;
  localparam int LEAKY_SHIFT = 3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) result = i + 1;
    return result;
  endfunction

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                      input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction
endpackage

// File: rtl/featuremap_adder_tree.sv
// Pipelined full-precision adder tree: one register stage for the lanes, then log2(CHANNELS) add stages.
module featuremap_adder_tree
  import conv_pkg::*;
#(
  parameter int CHANNELS   = 32,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = DATA_WIDTH + clog2(CHANNELS) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic signed [AW-1:0]           sum,
  output logic                           sum_vld
);
  localparam int S = clog2(CHANNELS);

  // Heap layout: leaves at CHANNELS..2*CHANNELS-1, root at 1; node i = node 2i + node 2i+1.
  logic signed [AW-1:0] node_p [1:2*CHANNELS-1];
  logic [S:0]           vld_p;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_p <= '0;
    else        vld_p <= {vld_p[S-1:0], valid_in};

  // Stage 0: sign-extend each lane
  for (genvar k = 0; k < CHANNELS; k++) begin : g_leaf
    logic signed [DATA_WIDTH-1:0] lane;
    assign lane = data_in[k*DATA_WIDTH +: DATA_WIDTH];
    always_ff @(posedge clk)
      if (valid_in) node_p[CHANNELS+k] <= AW'(lane);
  end

  // Stages 1..S: a node at depth d is loaded by the valid leaving stage S-d-1
  for (genvar i = 1; i < CHANNELS; i++) begin : g_node
    localparam int EN = S - clog2(i + 1);
    always_ff @(posedge clk)
      if (vld_p[EN]) node_p[i] <= node_p[2*i] + node_p[2*i+1];
  end

  assign sum     = node_p[1];
  assign sum_vld = vld_p[S];
endmodule

// File: rtl/featuremap_accumulator.sv
// Per-output-channel accumulator: adder tree, bias, activation, saturation and
// feature-map position tracking with row/frame end flags.
module featuremap_accumulator
  import conv_pkg::*;
#(
  parameter int                           CHANNELS   = 32,
  parameter int                           DATA_WIDTH = 16,
  parameter int                           FRAC_BITS  = 8,
  parameter int                           IMG_SIZE   = 104,
  parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0,
  parameter int                           ACT_MODE   = ACT_LEAKY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic                           line_end,
  output logic                           frame_end
);
  localparam int S  = clog2(CHANNELS);
  localparam int AW = DATA_WIDTH + S + 1;
  localparam int PW = (clog2(IMG_SIZE) < 1) ? 1 : clog2(IMG_SIZE);

  if (CHANNELS < 2 || CHANNELS > 256 || (1 << S) != CHANNELS) begin : g_bad_channels
    $error("featuremap_accumulator: CHANNELS=%0d must be a power of two in 2..256", CHANNELS);
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH || ACT_MODE < ACT_LINEAR || ACT_MODE > ACT_LEAKY)
  begin : g_bad_format
    $error("featuremap_accumulator: FRAC_BITS or ACT_MODE out of range");
  end

  function automatic logic signed [DATA_WIDTH-1:0] activate(input logic signed [AW-1:0] x);
    logic signed [AW-1:0] y;
    y = x;
    if (ACT_MODE != ACT_LINEAR && x < 0) begin
      if (ACT_MODE == ACT_RELU) y = '0;
      else                      y = x >>> LEAKY_SHIFT;
    end
    return DATA_WIDTH'(sat_to_width(64'(y), DATA_WIDTH));
  endfunction

  logic signed [AW-1:0] sum_tree;
  logic                 vld_tree;
  logic signed [AW-1:0] biased_p0;
  logic                 vld_p0;
  logic                 vld_p1;
  logic [PW-1:0]        col;
  logic [PW-1:0]        row;

  featuremap_adder_tree #(
    .CHANNELS  (CHANNELS),
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (AW)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .valid_in(valid_in),
    .sum     (sum_tree),
    .sum_vld (vld_tree)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= vld_tree;
      vld_p1 <= vld_p0;
    end

  // Bias stage
  always_ff @(posedge clk)
    if (vld_tree) biased_p0 <= sum_tree + AW'(BIAS);

  // Activation / saturation stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      data_out <= '0;
    else if (vld_p0) data_out <= activate(biased_p0);

  assign valid_out = vld_p1;
  assign line_end  = valid_out && (col == PW'(IMG_SIZE - 1));
  assign frame_end = line_end && (row == PW'(IMG_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_out) begin
      if (line_end) begin
        col <= '0;
        row <= frame_end ? '0 : row + PW'(1);
      end else begin
        col <= col + PW'(1);
      end
    end
endmodule
